// File: rtl/wb_stage.sv
// Write-back stage: retires the memory-stage instruction, drives the GPR and CSR write
// ports, commits exceptions and ertn, and flushes all upstream stages.
module wb_stage #(
  parameter int unsigned EX_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [31:0]     ms_pc,
  input  logic            ms_rf_we,
  input  logic [4:0]      ms_rf_waddr,
  input  logic [31:0]     ms_rf_wdata,
  input  logic            ms_csr_re,
  input  logic            ms_csr_we,
  input  logic [13:0]     ms_csr_num,
  input  logic [31:0]     ms_csr_wmask,
  input  logic [31:0]     ms_csr_wvalue,
  input  logic            ms_ertn,
  input  logic [EX_W-1:0] ms_ex_vec,
  input  logic [31:0]     ms_vaddr,
  output logic            csr_re,
  output logic [13:0]     csr_num,
  input  logic [31:0]     csr_rvalue,
  output logic            csr_we,
  output logic [31:0]     csr_wmask,
  output logic [31:0]     csr_wvalue,
  output logic            wb_ex,
  output logic [5:0]      wb_ecode,
  output logic [8:0]      wb_esubcode,
  output logic [31:0]     wb_pc,
  output logic [31:0]     wb_vaddr,
  output logic            ertn_flush,
  output logic            ws_flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     debug_wb_pc,
  output logic [3:0]      debug_wb_rf_we,
  output logic [4:0]      debug_wb_rf_wnum,
  output logic [31:0]     debug_wb_rf_wdata
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  logic            ws_valid;
  logic            ws_ready_go;
  logic            ws_has_ex;
  logic [31:0]     pc_r;
  logic            rf_we_r;
  logic [4:0]      rf_waddr_r;
  logic [31:0]     rf_wdata_r;
  logic            csr_re_r;
  logic            csr_we_r;
  logic [13:0]     csr_num_r;
  logic [31:0]     csr_wmask_r;
  logic [31:0]     csr_wvalue_r;
  logic            ertn_r;
  logic [EX_W-1:0] ex_vec_r;
  logic [31:0]     vaddr_r;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid && !ws_flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= '0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
      csr_re_r     <= 1'b0;
      csr_we_r     <= 1'b0;
      csr_num_r    <= '0;
      csr_wmask_r  <= '0;
      csr_wvalue_r <= '0;
      ertn_r       <= 1'b0;
      ex_vec_r     <= '0;
      vaddr_r      <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      pc_r         <= ms_pc;
      rf_we_r      <= ms_rf_we;
      rf_waddr_r   <= ms_rf_waddr;
      rf_wdata_r   <= ms_rf_wdata;
      csr_re_r     <= ms_csr_re;
      csr_we_r     <= ms_csr_we;
      csr_num_r    <= ms_csr_num;
      csr_wmask_r  <= ms_csr_wmask;
      csr_wvalue_r <= ms_csr_wvalue;
      ertn_r       <= ms_ertn;
      ex_vec_r     <= ms_ex_vec;
      vaddr_r      <= ms_vaddr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (ws_valid && !ws_has_ex) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign ws_has_ex = ws_valid && (|ex_vec_r);

  // Fixed-priority pick; lower flags are ignored once a higher one is set.
  always_comb begin
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_vaddr    = '0;
    if (ws_has_ex) begin
      if (ex_vec_r[0]) begin
        wb_ecode = ECODE_INT;
      end else if (ex_vec_r[1]) begin
        wb_ecode = ECODE_ADEF;
        wb_vaddr = pc_r;
      end else if (ex_vec_r[2]) begin
        wb_ecode = ECODE_INE;
      end else if (ex_vec_r[3]) begin
        wb_ecode = ECODE_SYS;
      end else if (ex_vec_r[4]) begin
        wb_ecode = ECODE_BRK;
      end else begin
        wb_ecode = ECODE_ALE;
        wb_vaddr = vaddr_r;
      end
    end
  end

  assign wb_ex      = ws_has_ex;
  assign wb_pc      = pc_r;
  assign ertn_flush = ws_valid && ertn_r && !(|ex_vec_r);
  assign ws_flush   = wb_ex || ertn_flush;

  assign csr_re     = ws_valid && csr_re_r;
  assign csr_we     = ws_valid && csr_we_r && !ws_has_ex;
  assign csr_num    = csr_num_r;
  assign csr_wmask  = csr_wmask_r;
  assign csr_wvalue = csr_wvalue_r;

  assign rf_we    = ws_valid && rf_we_r && !ws_has_ex && (rf_waddr_r != 5'd0);
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = csr_re_r ? csr_rvalue : rf_wdata_r;

  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr_r;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back pipeline stage; holds the instruction retiring from the memory stage.
- Drives register-file write-back and the CSR access port (read, write, mask and value).
- Arbitrates pending exception flags into an ecode/esubcode and raises wb_ex or ertn_flush toward the CSR file.
- Produces a pipeline flush for all upstream stages and the debug trace interface.

Parameters:
- EX_W, 6, width of exception vector from memory stage (fixed bit assignment below).

Ports:
- clk in 1: clock.
- rst in 1: asynchronous active-high reset.
- ms_to_ws_valid in 1: memory stage presents an instruction.
- ws_allowin out 1: stage can accept this cycle.
- ms_pc in 32: instruction PC.
- ms_rf_we in 1: GPR write request.
- ms_rf_waddr in 5: destination GPR.
- ms_rf_wdata in 32: ALU/load result.
- ms_csr_re in 1: instruction reads a CSR (csrrd/csrwr/csrxchg).
- ms_csr_we in 1: instruction writes a CSR.
- ms_csr_num in 14: CSR number.
- ms_csr_wmask in 32: CSR write mask.
- ms_csr_wvalue in 32: CSR write data.
- ms_ertn in 1: instruction is ertn.
- ms_ex_vec in EX_W: bit0 INT, bit1 ADEF, bit2 INE, bit3 SYS, bit4 BRK, bit5 ALE.
- ms_vaddr in 32: memory access address.
- csr_re out 1: CSR read enable.
- csr_num out 14: CSR number.
- csr_rvalue in 32: CSR read data (combinational).
- csr_we out 1: CSR write enable.
- csr_wmask out 32: CSR write mask.
- csr_wvalue out 32: CSR write data.
- wb_ex out 1: exception commit.
- wb_ecode out 6: exception primary code.
- wb_esubcode out 9: exception subcode.
- wb_pc out 32: PC of excepting instruction.
- wb_vaddr out 32: faulting address.
- ertn_flush out 1: ertn commit.
- ws_flush out 1: cancel all upstream instructions (= wb_ex | ertn_flush).
- rf_we out 1: GPR write enable.
- rf_waddr out 5: GPR address.
- rf_wdata out 32: GPR data.
- retired_cnt out 32: count of retired non-excepting instructions.
- debug_wb_pc out 32: trace PC.
- debug_wb_rf_we out 4: trace write strobe.
- debug_wb_rf_wnum out 5: trace GPR number.
- debug_wb_rf_wdata out 32: trace GPR data.

Behaviour:
- Reset (async, rst=1): ws_valid=0; all pipeline registers 0; retired_cnt=0. All write/commit outputs are therefore 0 and ws_allowin=1.
- ws_ready_go=1 always; ws_allowin = !ws_valid | ws_ready_go (=1).
- Capture edge: on posedge clk with ws_allowin:
  - ws_valid <= ms_to_ws_valid & !ws_flush.
  - Payload registers load when ms_to_ws_valid & ws_allowin.
  - Net effect: an instruction arriving in the flush cycle is dropped and ws_valid is 0 the next cycle.
- ws_has_ex = ws_valid & |ex_vec_r.
- Exception priority (highest first), with {ecode, esubcode}:
  - INT: 0x00, 0.
  - ADEF: 0x08, 0.
  - INE: 0x0D, 0.
  - SYS: 0x0B, 0.
  - BRK: 0x0C, 0.
  - ALE: 0x09, 0.
  - Lower-priority flags are ignored when a higher one is set.
- wb_ex = ws_has_ex; wb_pc = pc_r.
- wb_vaddr = vaddr_r for ALE, pc_r for ADEF, 0 otherwise.
- wb_ecode/wb_esubcode are 0 when !wb_ex.
- ertn_flush = ws_valid & ertn_r & !|ex_vec_r. An exception wins over ertn.
- ws_flush is a single-cycle pulse; the next cycle ws_valid=0, so wb_ex is never held for 2 cycles.
- CSR port:
  - csr_re = ws_valid & csr_re_r.
  - csr_we = ws_valid & csr_we_r & !ws_has_ex.
  - csr_num/wmask/wvalue driven from registers unconditionally.
- Register file:
  - rf_we = ws_valid & rf_we_r & !ws_has_ex & (rf_waddr_r != 0).
  - rf_wdata = csr_re_r ? csr_rvalue : rf_wdata_r.
- Debug trace:
  - debug_wb_pc = pc_r.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = rf_waddr_r.
  - debug_wb_rf_wdata = rf_wdata.
- retired_cnt: +1 each cycle with ws_valid & !ws_has_ex (ertn counts); wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: pending instruction discarded immediately (async); no write, no wb_ex after rst.

Test Plan:
- Reset, then add r5=0x1234 at pc 0x1C000000 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, debug_wb_rf_we=0xF, retired_cnt=1.
- csrrd r4, CSR 0x6 with csr_rvalue=0xABCD -> csr_re=1, csr_num=0x6, rf_wdata=0xABCD, csr_we=0.
- syscall at pc 0x1C000040 (ex_vec=0x08) -> wb_ex=1, wb_ecode=0x0B, wb_pc=0x1C000040, rf_we=0, ws_flush=1 for 1 cycle; instruction offered same cycle dropped (ws_valid=0 next cycle); retired_cnt unchanged.
- ex_vec=0x21 (INT+ALE), ms_vaddr=0x8003 -> wb_ecode=0x00, wb_vaddr=0. ex_vec=0x20 alone -> wb_ecode=0x09, wb_vaddr=0x8003. ex_vec=0x02 at pc 0x1C000101 -> ecode 0x08, esubcode 0, wb_vaddr=0x1C000101.
- ertn with ex_vec=0 -> ertn_flush=1, wb_ex=0. ertn with ex_vec=0x04 -> wb_ex=1, ecode 0x0D, ertn_flush=0. csrwr with ex_vec=0x01 -> csr_we=0.
- Force retired_cnt to 0xFFFFFFFF via 2^32 retirements (or backdoor) -> next retire gives 0. Assert rst mid-instruction -> all outputs 0 without waiting for a clock edge.
